// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants and types for the Sobel row feeder
//
// Purpose: pixel width, default array geometry, the feeder state type and a
//          counter-width helper shared by sobel_row_collect and sobel_row_feeder.
// Ports:   none (package).
package sobel_pkg;

   localparam int PIX_W          = 8;
   localparam int DEF_NUM_COLS   = 8;
   localparam int DEF_IMG_H      = 16;
   localparam int DEF_FLUSH_ROWS = 3;

   typedef enum logic {
      FILL  = 1'b0,
      FLUSH = 1'b1
   } feeder_state_t;

   // Width of a counter that steps through num_states values (0..num_states-1).
   // Never narrower than one bit so degenerate geometries still elaborate.
   function automatic int cnt_w(input int num_states);
      return (num_states > 1) ? $clog2(num_states) : 1;
   endfunction

endpackage

// File: rtl/sobel_row_collect.sv
// rtl/sobel_row_collect.sv - serial-to-parallel pixel collect buffer
//
// Purpose: gathers raster-order pixels into NUM_COLS slots and presents the
//          completed row combinationally on the cycle of its last pixel.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   push       - a pixel transfers this cycle
//   pixel      - incoming pixel
//   row_last   - the slot being written is the last column of the row
//   row_word   - buffer contents with the incoming pixel merged at col_cnt;
//                column c on bits [8c+7:8c]
module sobel_row_collect
   import sobel_pkg::*;
#(
   parameter int NUM_COLS = DEF_NUM_COLS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [PIX_W-1:0]          pixel,
   output logic                      row_last,
   output logic [NUM_COLS*PIX_W-1:0] row_word
);

   localparam int CW = cnt_w(NUM_COLS);

   logic [CW-1:0]             col_cnt;
   logic [NUM_COLS*PIX_W-1:0] slots;

   // Merging the live pixel here lets the top capture a full row on the same
   // edge that accepts the last pixel, giving one cycle of latency.
   always_comb begin
      row_word = slots;
      row_word[int'(col_cnt)*PIX_W +: PIX_W] = pixel;
   end

   assign row_last = (col_cnt == CW'(NUM_COLS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt <= '0;
         slots   <= '0;
      end else if (push) begin
         slots   <= row_word;
         col_cnt <= row_last ? '0 : col_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/sobel_row_feeder.sv
// rtl/sobel_row_feeder.sv - raster pixel stream to parallel rows for a Sobel PE array
//
// Purpose: collects NUM_COLS pixels per row, presents each row in parallel with a
//          one-cycle row_valid pulse, and after IMG_H rows emits FLUSH_ROWS zero
//          rows to drain the downstream pipeline, pulsing frame_done on the last.
// Build option: SOBEL_FEEDER_EDGE_REPLICATE_EN
//          defined   - left_edge/right_edge replicate columns 0 and NUM_COLS-1
//          undefined - left_edge/right_edge are always zero
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   s_pixel    - raster-order input pixel
//   s_valid    - s_pixel is valid
//   s_ready    - feeder accepts s_pixel this cycle (low during flush)
//   row_out    - parallel row, column c on bits [8c+7:8c]
//   left_edge  - left neighbour for PE column 0
//   right_edge - right neighbour for PE column NUM_COLS-1
//   row_valid  - one-cycle pulse when row_out holds a new row
//   frame_done - one-cycle pulse on the final flush row
module sobel_row_feeder
   import sobel_pkg::*;
#(
   parameter int NUM_COLS   = DEF_NUM_COLS,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int FLUSH_ROWS = DEF_FLUSH_ROWS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [PIX_W-1:0]          s_pixel,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [NUM_COLS*PIX_W-1:0] row_out,
   output logic [PIX_W-1:0]          left_edge,
   output logic [PIX_W-1:0]          right_edge,
   output logic                      row_valid,
   output logic                      frame_done
);

   localparam int RW = cnt_w(IMG_H);
   localparam int FW = cnt_w(FLUSH_ROWS);

   feeder_state_t state;
   feeder_state_t state_next;

   logic [RW-1:0] row_cnt;
   logic [FW-1:0] flush_cnt;

   logic                      accept;
   logic                      row_last;
   logic                      load_row;
   logic                      load_zero;
   logic                      done_next;
   logic [NUM_COLS*PIX_W-1:0] row_word;
   logic [PIX_W-1:0]          left_next;
   logic [PIX_W-1:0]          right_next;

   sobel_row_collect #(
      .NUM_COLS (NUM_COLS)
   ) u_collect (
      .clk      (clk),
      .rst      (rst),
      .push     (accept),
      .pixel    (s_pixel),
      .row_last (row_last),
      .row_word (row_word)
   );

`ifdef SOBEL_FEEDER_EDGE_REPLICATE_EN
   assign left_next  = row_word[PIX_W-1:0];
   assign right_next = row_word[NUM_COLS*PIX_W-1 -: PIX_W];
`else
   assign left_next  = '0;
   assign right_next = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      accept     = 1'b0;
      load_row   = 1'b0;
      load_zero  = 1'b0;
      done_next  = 1'b0;
      case (state)
         FILL: begin
            s_ready = 1'b1;
            accept  = s_valid;
            if (s_valid && row_last) begin
               load_row = 1'b1;
               if (row_cnt == RW'(IMG_H - 1)) begin
                  state_next = FLUSH;
               end
            end
         end
         FLUSH: begin
            load_zero = 1'b1;
            if (flush_cnt == FW'(FLUSH_ROWS - 1)) begin
               done_next  = 1'b1;
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   // Output registers are separate from the collect slots, so the next row can
   // start filling on the cycle right after a row is captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt    <= '0;
         flush_cnt  <= '0;
         row_out    <= '0;
         left_edge  <= '0;
         right_edge <= '0;
         row_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         row_valid  <= load_row | load_zero;
         frame_done <= done_next;
         if (load_row) begin
            row_out    <= row_word;
            left_edge  <= left_next;
            right_edge <= right_next;
            row_cnt    <= (row_cnt == RW'(IMG_H - 1)) ? '0 : row_cnt + RW'(1);
         end else if (load_zero) begin
            row_out    <= '0;
            left_edge  <= '0;
            right_edge <= '0;
            flush_cnt  <= done_next ? '0 : flush_cnt + FW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sobel_row_feeder.sv
// tb/tb_sobel_row_feeder.sv - self-checking bench for sobel_row_feeder
module tb_sobel_row_feeder;

   localparam int NC   = 8;
   localparam int IH   = 2;
   localparam int FR   = 3;
   localparam int RWID = NC * 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      s_pixel = 8'h00;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [RWID-1:0] row_out;
   logic [7:0]      left_edge;
   logic [7:0]      right_edge;
   logic            row_valid;
   logic            frame_done;

   always #5 clk = ~clk;

   sobel_row_feeder #(
      .NUM_COLS   (NC),
      .IMG_H      (IH),
      .FLUSH_ROWS (FR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_pixel    (s_pixel),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .row_out    (row_out),
      .left_edge  (left_edge),
      .right_edge (right_edge),
      .row_valid  (row_valid),
      .frame_done (frame_done)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [RWID-1:0] act, input logic [RWID-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of pixels for the row in progress, a count of
   // finished rows in the frame, and a count of zero rows still owed.
   logic [7:0]      m_part[$];
   int              m_rows  = 0;
   int              m_flush = 0;
   logic [RWID-1:0] e_row   = '0;
   logic [7:0]      e_left  = 8'h00;
   logic [7:0]      e_right = 8'h00;
   logic            e_valid = 1'b0;
   logic            e_done  = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_part.delete();
         m_rows  = 0;
         m_flush = 0;
         e_row   = '0;
         e_left  = 8'h00;
         e_right = 8'h00;
         e_valid = 1'b0;
         e_done  = 1'b0;
      end else begin
         e_valid = 1'b0;
         e_done  = 1'b0;
         if (m_flush > 0) begin
            e_row   = '0;
            e_left  = 8'h00;
            e_right = 8'h00;
            e_valid = 1'b1;
            m_flush = m_flush - 1;
            if (m_flush == 0) e_done = 1'b1;
         end else if (s_valid) begin
            m_part.push_back(s_pixel);
            if (m_part.size() == NC) begin
               e_row = '0;
               for (int i = 0; i < NC; i++) e_row[i*8 +: 8] = m_part[i];
`ifdef SOBEL_FEEDER_EDGE_REPLICATE_EN
               e_left  = m_part[0];
               e_right = m_part[NC-1];
`else
               e_left  = 8'h00;
               e_right = 8'h00;
`endif
               e_valid = 1'b1;
               m_part.delete();
               m_rows = m_rows + 1;
               if (m_rows == IH) begin
                  m_rows  = 0;
                  m_flush = FR;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("s_ready",    RWID'(s_ready),    RWID'(m_flush == 0));
         chk("row_valid",  RWID'(row_valid),  RWID'(e_valid));
         chk("frame_done", RWID'(frame_done), RWID'(e_done));
         chk("row_out",    row_out,           e_row);
         chk("left_edge",  RWID'(left_edge),  RWID'(e_left));
         chk("right_edge", RWID'(right_edge), RWID'(e_right));
      end
   end

   task automatic send(input logic [7:0] pix);
      s_valid = 1'b1;
      s_pixel = pix;
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int nz;
      int nv;
      int dk;
      int nd;
      int gap_pulses;

      rst = 1'b1;
      idle(2);
      chk_en = 1'b1;
      chk("rst_s_ready",    RWID'(s_ready),    RWID'(1));
      chk("rst_row_valid",  RWID'(row_valid),  RWID'(0));
      chk("rst_row_out",    row_out,           '0);
      chk("rst_frame_done", RWID'(frame_done), RWID'(0));
      rst = 1'b0;

      // Back-to-back row 1..8: row_valid one cycle after pixel 8.
      for (int i = 1; i <= NC; i++) send(8'(i));
      chk("row1_valid", RWID'(row_valid), RWID'(1));
      chk("row1_data",  row_out, 64'h0807060504030201);
      chk("row1_model", e_row,   64'h0807060504030201);
      chk("row1_ready", RWID'(s_ready), RWID'(1));

      // Same row with a 3-cycle gap after pixel 4; completes the frame.
      gap_pulses = 0;
      for (int i = 1; i <= 4; i++) send(8'(i));
      for (int g = 0; g < 3; g++) begin
         if (row_valid) gap_pulses++;
         idle(1);
      end
      chk("gap_no_pulse", RWID'(gap_pulses), RWID'(0));
      for (int i = 5; i <= NC; i++) send(8'(i));
      chk("row2_valid", RWID'(row_valid), RWID'(1));
      chk("row2_data",  row_out, 64'h0807060504030201);

      // Flush window: s_valid held high while flushing must be ignored.
      nz = 0; nv = 0; dk = -1;
      for (int k = 0; k < 5; k++) begin
         if (!s_ready) nz++;
         if (k > 0 && row_valid) nv++;
         if (frame_done) dk = k;
         s_valid = (k < 3);
         s_pixel = 8'hEE;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      chk("flush_ready_low", RWID'(nz), RWID'(3));
      chk("flush_rows",      RWID'(nv), RWID'(3));
      chk("flush_done_pos",  RWID'(dk), RWID'(3));

      // Edge handling on row 0x10..0x17.
      for (int i = 0; i < NC; i++) send(8'(8'h10 + i));
      chk("edge_row", row_out, 64'h1716151413121110);
`ifdef SOBEL_FEEDER_EDGE_REPLICATE_EN
      chk("edge_left",  RWID'(left_edge),  RWID'(8'h10));
      chk("edge_right", RWID'(right_edge), RWID'(8'h17));
`else
      chk("edge_left",  RWID'(left_edge),  RWID'(8'h00));
      chk("edge_right", RWID'(right_edge), RWID'(8'h00));
`endif

      // Reset mid-row discards the partial row.
      for (int i = 0; i < 5; i++) send(8'h55);
      rst = 1'b1;
      idle(1);
      chk("midrow_rst_valid", RWID'(row_valid), RWID'(0));
      rst = 1'b0;
      idle(1);
      chk("post_rst_valid", RWID'(row_valid), RWID'(0));
      for (int i = 0; i < NC; i++) send(8'(8'hA0 + i));
      chk("rst_row_data",  row_out, 64'hA7A6A5A4A3A2A1A0);
      chk("rst_row_valid", RWID'(row_valid), RWID'(1));

      // Reset during flush: frame_done must never pulse.
      for (int i = 0; i < NC; i++) send(8'($urandom));
      chk("flush_entry_ready", RWID'(s_ready), RWID'(0));
      idle(1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("flush_rst_ready", RWID'(s_ready), RWID'(1));
      nd = 0;
      for (int k = 0; k < 6; k++) begin
         if (frame_done) nd++;
         idle(1);
      end
      chk("flush_rst_no_done", RWID'(nd), RWID'(0));

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 600; c++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_pixel = 8'($urandom);
         rst     = ($urandom_range(0, 79) == 0);
         @(posedge clk); #1;
      end
      rst     = 1'b0;
      s_valid = 1'b0;
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
